// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the picorv32 memory-bus decoder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // Wait-state nibble for slave idx, from a zero-extended SLAVE_LAT
  function automatic logic [3:0] lat_of(
    input logic [63:0] lat,
    input logic [3:0]  idx
  );
    return lat[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// Loadable 8-bit counter: counts down to zero for wait states,
// or up to LIMIT for handshake timeout.
module mem_bus_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic       up,
  output logic       hit
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (up) begin
        count <= count + 8'd1;
      end else if (count != 8'd0) begin
        count <= count - 8'd1;
      end
    end
  end

  assign hit = up ? (count == LIMIT) : (count == 8'd0);

endmodule

// File: rtl/mem_bus_decoder.sv
// Address-decoding bus fabric between the picorv32 native port
// and up to 16 slaves, with wait-state/handshake completion.
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int                      NUM_SLAVES = 8,
  parameter int                      SEL_HI     = 15,
  parameter int                      SEL_LO     = 12,
  parameter logic [NUM_SLAVES*4-1:0] SLAVE_LAT  = '0,
  parameter logic [NUM_SLAVES-1:0]   SLAVE_HS   = '0,
  parameter int                      TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_valid,
  input  logic [31:0]              cpu_addr,
  input  logic [3:0]               cpu_wstrb,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  output logic [NUM_SLAVES-1:0]    slv_cs,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  output logic                     bus_err,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int          IW    = SEL_HI - SEL_LO + 1;
  localparam logic [15:0] HS16  = 16'(SLAVE_HS);
  localparam logic [63:0] LAT64 = 64'(SLAVE_LAT);

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic [3:0]    sel;
  logic [3:0]    sel_q;
  logic          hs;
  logic [15:0]   rdy16;
  logic [511:0]  rd512;
  logic [31:0]   rd_sel;
  logic [7:0]    t_val;
  logic          hit;
  logic          start;
  logic          done;
  logic          fail;
  logic          unused_ok;

  assign idx    = cpu_addr[SEL_HI:SEL_LO];
  assign sel    = 4'(idx);
  assign hs     = HS16[sel_q];
  assign rdy16  = 16'(slv_ready);
  assign rd512  = 512'(slv_rdata);
  assign rd_sel = rd512[{sel_q, 5'd0} +: 32];
  assign t_val  = HS16[sel] ? 8'd0 : {4'd0, lat_of(LAT64, sel)};

  // Write strobes go straight to the slaves
  assign unused_ok = ^cpu_wstrb;

  mem_bus_timer #(
    .LIMIT (8'(TIMEOUT))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (t_val),
    .en       (state == WAIT),
    .up       (hs),
    .hit      (hit)
  );

  always_comb begin
    state_n = state;
    start   = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_valid) begin
          if (32'(idx) >= NUM_SLAVES) begin
            fail    = 1'b1;
            state_n = ACK;
          end else begin
            start   = 1'b1;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        // Ready beats timeout when both land on the same edge
        if (!cpu_valid) begin
          state_n = IDLE;
        end else if (hs ? rdy16[sel_q] : hit) begin
          done    = 1'b1;
          state_n = ACK;
        end else if (hs && hit) begin
          fail    = 1'b1;
          state_n = ACK;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= 4'd0;
      slv_cs    <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= 32'd0;
      bus_err   <= 1'b0;
      err_addr  <= 32'd0;
      err_count <= 8'd0;
    end else begin
      state     <= state_n;
      cpu_ready <= done | fail;
      bus_err   <= fail;
      if (start) begin
        sel_q  <= sel;
        slv_cs <= NUM_SLAVES'(1) << sel;
      end else if (state_n != WAIT) begin
        slv_cs <= '0;
      end
      if (done) begin
        cpu_rdata <= rd_sel;
      end
      if (fail) begin
        cpu_rdata <= ERR_RDATA;
        err_addr  <= cpu_addr;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed bench for mem_bus_decoder: 4 slaves, slave 3 handshake.
module tb_mem_bus_decoder;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid;
  logic [31:0]   cpu_addr;
  logic [3:0]    cpu_wstrb;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic [N-1:0]  slv_cs;
  logic [N-1:0]  slv_ready;
  logic [N*32-1:0] slv_rdata;
  logic          bus_err;
  logic [31:0]   err_addr;
  logic [7:0]    err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_decoder #(
    .NUM_SLAVES (N),
    .SEL_HI     (15),
    .SEL_LO     (12),
    .SLAVE_LAT  (16'h0120),
    .SLAVE_HS   (4'b1000),
    .TIMEOUT    (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wstrb (cpu_wstrb),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .slv_cs    (slv_cs),
    .slv_ready (slv_ready),
    .slv_rdata (slv_rdata),
    .bus_err   (bus_err),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] w);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_wstrb = w;
  endtask

  // Cycles from request drive until cpu_ready; -1 if it never comes
  task automatic run(output int lat, output int cs_cnt,
                     output logic [N-1:0] cs_or);
    lat    = -1;
    cs_cnt = 0;
    cs_or  = '0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (cpu_ready) begin
        lat = i + 1;
        break;
      end
      if (slv_cs != '0) cs_cnt++;
      cs_or = cs_or | slv_cs;
    end
  endtask

  task automatic finish_ack();
    cpu_valid = 1'b0;
    cpu_wstrb = 4'd0;
    tick();
  endtask

  int           lat;
  int           csn;
  logic [N-1:0] cso;
  int           nbad;

  initial begin
    rst       = 1'b1;
    cpu_valid = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wstrb = 4'd0;
    slv_ready = '0;
    slv_rdata = {32'h3333_3333, 32'h2222_2222,
                 32'hCAFE_F00D, 32'h1111_1111};
    tick();
    tick();
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_cs", 32'(slv_cs), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_eaddr", err_addr, 32'd0);
    chk("rst_ecnt", 32'(err_count), 32'd0);
    rst = 1'b0;
    tick();

    // Fixed slave 1, latency 2
    req(32'h0000_1004, 4'd0);
    run(lat, csn, cso);
    chk("fx1_lat", lat, 32'd4);
    chk("fx1_cscnt", csn, 32'd3);
    chk("fx1_cs", 32'(cso), 32'h2);
    chk("fx1_rdata", cpu_rdata, 32'hCAFE_F00D);
    chk("fx1_err", 32'(bus_err), 32'd0);
    chk("fx1_ackcs", 32'(slv_cs), 32'd0);
    finish_ack();
    chk("fx1_single", 32'(cpu_ready), 32'd0);

    // Fixed slave 0, latency 0
    req(32'h0000_0000, 4'd0);
    run(lat, csn, cso);
    chk("fx0_lat", lat, 32'd2);
    chk("fx0_cscnt", csn, 32'd1);
    chk("fx0_rdata", cpu_rdata, 32'h1111_1111);
    finish_ack();

    // Fixed slave 2, latency 1, write
    req(32'h0000_2008, 4'hF);
    run(lat, csn, cso);
    chk("fx2_lat", lat, 32'd3);
    chk("fx2_cs", 32'(cso), 32'h4);
    chk("fx2_err", 32'(bus_err), 32'd0);
    finish_ack();

    // Handshake write to slave 3, stray ready on slave 2
    req(32'h0000_3000, 4'b0001);
    tick();
    chk("hs_cs", 32'(slv_cs), 32'h8);
    slv_ready = 4'b0100;
    nbad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_ready || slv_cs != 4'b1000) nbad++;
    end
    chk("hs_wait", nbad, 32'd0);
    slv_ready = 4'b1000;
    tick();
    slv_ready = '0;
    chk("hs_ready", 32'(cpu_ready), 32'd1);
    chk("hs_ackcs", 32'(slv_cs), 32'd0);
    chk("hs_err", 32'(bus_err), 32'd0);
    chk("hs_rdata", cpu_rdata, 32'h3333_3333);
    finish_ack();
    chk("hs_single", 32'(cpu_ready), 32'd0);

    // Unmapped addresses
    req(32'h0000_7000, 4'd0);
    run(lat, csn, cso);
    chk("um_lat", lat, 32'd1);
    chk("um_err", 32'(bus_err), 32'd1);
    chk("um_rdata", cpu_rdata, 32'd0);
    chk("um_eaddr", err_addr, 32'h0000_7000);
    chk("um_ecnt", 32'(err_count), 32'd1);
    chk("um_cs", 32'(cso | slv_cs), 32'd0);
    finish_ack();
    chk("um_errpulse", 32'(bus_err), 32'd0);
    req(32'h0000_4000, 4'h3);
    run(lat, csn, cso);
    chk("um4_err", 32'(bus_err), 32'd1);
    chk("um4_ecnt", 32'(err_count), 32'd2);
    finish_ack();

    // Handshake timeout: ready 11 cycles after WAIT entry
    req(32'h0000_3010, 4'd0);
    run(lat, csn, cso);
    chk("to_lat", lat, 32'd12);
    chk("to_cscnt", csn, 32'd11);
    chk("to_err", 32'(bus_err), 32'd1);
    chk("to_rdata", cpu_rdata, 32'd0);
    chk("to_eaddr", err_addr, 32'h0000_3010);
    chk("to_ecnt", 32'(err_count), 32'd3);
    finish_ack();

    // Ready on the timeout edge wins
    req(32'h0000_3020, 4'd0);
    for (int i = 0; i < 11; i++) tick();
    chk("sim_pre", 32'(cpu_ready), 32'd0);
    slv_ready = 4'b1000;
    tick();
    slv_ready = '0;
    chk("sim_ready", 32'(cpu_ready), 32'd1);
    chk("sim_err", 32'(bus_err), 32'd0);
    chk("sim_rdata", cpu_rdata, 32'h3333_3333);
    chk("sim_ecnt", 32'(err_count), 32'd3);
    finish_ack();

    // Back-to-back: second cs two cycles after first ready
    req(32'h0000_0000, 4'd0);
    run(lat, csn, cso);
    chk("b2b_r1", 32'(cpu_ready), 32'd1);
    cpu_addr = 32'h0000_1000;
    tick();
    chk("b2b_cs_a", 32'(slv_cs), 32'd0);
    chk("b2b_rdy_a", 32'(cpu_ready), 32'd0);
    tick();
    chk("b2b_cs_b", 32'(slv_cs), 32'h2);
    run(lat, csn, cso);
    chk("b2b_lat", lat, 32'd3);
    chk("b2b_rdata", cpu_rdata, 32'hCAFE_F00D);
    finish_ack();

    // Abort mid-WAIT
    req(32'h0000_3000, 4'd0);
    tick();
    tick();
    tick();
    cpu_valid = 1'b0;
    tick();
    chk("ab_cs", 32'(slv_cs), 32'd0);
    chk("ab_ready", 32'(cpu_ready), 32'd0);
    nbad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cpu_ready || bus_err || slv_cs != '0) nbad++;
    end
    chk("ab_quiet", nbad, 32'd0);
    req(32'h0000_1000, 4'd0);
    run(lat, csn, cso);
    chk("ab_next", lat, 32'd4);
    finish_ack();

    // Saturating error counter
    nbad = 0;
    for (int k = 0; k < 300; k++) begin
      req(32'h0000_3000, 4'd0);
      run(lat, csn, cso);
      if (lat != 12 || !bus_err) nbad++;
      finish_ack();
      if (k == 250) chk("sat_254", 32'(err_count), 32'd254);
    end
    chk("sat_lat", nbad, 32'd0);
    chk("sat_255", 32'(err_count), 32'd255);

    // Reset mid-WAIT
    req(32'h0000_1000, 4'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mr_cs", 32'(slv_cs), 32'd0);
    chk("mr_ready", 32'(cpu_ready), 32'd0);
    chk("mr_rdata", cpu_rdata, 32'd0);
    chk("mr_ecnt", 32'(err_count), 32'd0);
    chk("mr_eaddr", err_addr, 32'd0);
    rst = 1'b0;
    cpu_valid = 1'b0;
    tick();
    tick();
    chk("mr_after", 32'(cpu_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
